cpu_control_unit: RTL and testbench

//  Multi-cycle FSM that sequences the 16-bit execution unit (PC, IR, register file, ALU).
//  Per instruction: fetch, decode, execute.

---
 rtl/cpu_control_unit_if.sv | 38 +++
 rtl/cpu_control_unit.sv | 190 +++++++++++++++++++
 tb/tb_cpu_control_unit.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_control_unit_if.sv
// rtl/cpu_control_unit_if.sv - control unit <-> exec unit / memory signal bundle
interface cpu_control_unit_if;
  // Exec-unit status and memory acknowledge into the control unit
  logic [15:0] IR;
  logic        C;
  logic        N;
  logic        Z;
  logic        mem_ack;

  // Exec-unit controls and memory request out of the control unit
  logic        adr_sel;
  logic        s_sel;
  logic        pc_sel;
  logic        pc_ld;
  logic        pc_inc;
  logic        ir_ld;
  logic        W_en;
  logic [2:0]  W_Adr;
  logic [2:0]  R_Adr;
  logic [2:0]  S_Adr;
  logic [3:0]  ALU_OP;
  logic        mem_req;
  logic        mem_we;
  logic        halted;
  logic [3:0]  state;

  modport master (
    input  IR, C, N, Z, mem_ack,
    output adr_sel, s_sel, pc_sel, pc_ld, pc_inc, ir_ld, W_en,
           W_Adr, R_Adr, S_Adr, ALU_OP, mem_req, mem_we, halted, state
  );

  modport slave (
    output IR, C, N, Z, mem_ack,
    input  adr_sel, s_sel, pc_sel, pc_ld, pc_inc, ir_ld, W_en,
           W_Adr, R_Adr, S_Adr, ALU_OP, mem_req, mem_we, halted, state
  );
endinterface

// File: rtl/cpu_control_unit.sv
// rtl/cpu_control_unit.sv - fetch/decode/execute sequencer for the 16-bit exec unit
module cpu_control_unit #(
  parameter logic [3:0] ALU_PASS_S = 4'h1,
  parameter logic [3:0] ALU_PASS_R = 4'h2
) (
  input  logic               clk,
  input  logic               reset,
  cpu_control_unit_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_ALU    = 4'd2,
    S_LD     = 4'd3,
    S_ST     = 4'd4,
    S_BR     = 4'd5,
    S_JR     = 4'd6,
    S_HALT   = 4'd7
  } state_t;

  state_t state_q, state_d;
  logic   cf_q, nf_q, zf_q;
  logic   cf_d, nf_d, zf_d;

  logic       adr_sel, s_sel, pc_sel, pc_ld, pc_inc, ir_ld, w_en;
  logic       mem_req, mem_we, halted;
  logic [2:0] w_adr, r_adr, s_adr;
  logic [3:0] alu_op;
  logic [3:0] op;

  // IR[2:0] only carries the low branch-offset bits, which the exec unit consumes
  logic unused_ir_bits;
  assign unused_ir_bits = ^bus.IR[2:0];

  assign op = bus.IR[15:12];

  // Next-state, flag capture and Mealy control outputs; reset forces a quiet cycle
  always_comb begin
    state_d = state_q;
    cf_d    = cf_q;
    nf_d    = nf_q;
    zf_d    = zf_q;
    adr_sel = 1'b0;
    s_sel   = 1'b0;
    pc_sel  = 1'b0;
    pc_ld   = 1'b0;
    pc_inc  = 1'b0;
    ir_ld   = 1'b0;
    w_en    = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    halted  = 1'b0;
    alu_op  = 4'h0;
    w_adr   = 3'd0;
    r_adr   = 3'd0;
    s_adr   = 3'd0;

    // During FETCH the IR still holds the previous instruction, so keep addresses quiet
    if (state_q != S_FETCH) begin
      w_adr = bus.IR[11:9];
      r_adr = bus.IR[8:6];
      s_adr = bus.IR[5:3];
    end

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_ack) begin
          ir_ld   = 1'b1;
          pc_inc  = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op <= 4'h9) begin
          state_d = S_ALU;
        end else begin
          case (op)
            4'hA:        state_d = S_LD;
            4'hB:        state_d = S_ST;
            4'hC, 4'hE:  state_d = S_BR;
            4'hD:        state_d = S_JR;
            default:     state_d = S_HALT;
          endcase
        end
      end
      S_ALU: begin
        alu_op  = op;
        w_en    = 1'b1;
        cf_d    = bus.C;
        nf_d    = bus.N;
        zf_d    = bus.Z;
        state_d = S_FETCH;
      end
      S_LD: begin
        adr_sel = 1'b1;
        mem_req = 1'b1;
        if (bus.mem_ack) begin
          s_sel   = 1'b1;
          alu_op  = ALU_PASS_S;
          w_en    = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_ST: begin
        // Store data and address are held unchanged for the whole wait
        adr_sel = 1'b1;
        alu_op  = ALU_PASS_S;
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (bus.mem_ack) begin
          state_d = S_FETCH;
        end
      end
      S_BR: begin
        // Offset is added to the PC already incremented by the fetch
        if ((op == 4'hC && zf_q) || (op == 4'hE && nf_q)) begin
          pc_ld = 1'b1;
        end
        state_d = S_FETCH;
      end
      S_JR: begin
        alu_op  = ALU_PASS_R;
        pc_sel  = 1'b1;
        pc_ld   = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (reset) begin
      state_d = S_FETCH;
      cf_d    = 1'b0;
      nf_d    = 1'b0;
      zf_d    = 1'b0;
      adr_sel = 1'b0;
      s_sel   = 1'b0;
      pc_sel  = 1'b0;
      pc_ld   = 1'b0;
      pc_inc  = 1'b0;
      ir_ld   = 1'b0;
      w_en    = 1'b0;
      mem_req = 1'b0;
      mem_we  = 1'b0;
      halted  = 1'b0;
      alu_op  = 4'h0;
      w_adr   = 3'd0;
      r_adr   = 3'd0;
      s_adr   = 3'd0;
    end
  end

  // State and latched branch flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cf_q    <= 1'b0;
      nf_q    <= 1'b0;
      zf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cf_q    <= cf_d;
      nf_q    <= nf_d;
      zf_q    <= zf_d;
    end
  end

  assign bus.adr_sel = adr_sel;
  assign bus.s_sel   = s_sel;
  assign bus.pc_sel  = pc_sel;
  assign bus.pc_ld   = pc_ld;
  assign bus.pc_inc  = pc_inc;
  assign bus.ir_ld   = ir_ld;
  assign bus.W_en    = w_en;
  assign bus.W_Adr   = w_adr;
  assign bus.R_Adr   = r_adr;
  assign bus.S_Adr   = s_adr;
  assign bus.ALU_OP  = alu_op;
  assign bus.mem_req = mem_req;
  assign bus.mem_we  = mem_we;
  assign bus.halted  = halted;
  assign bus.state   = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb/tb_cpu_control_unit.sv - randomized trace-model bench for cpu_control_unit
module tb_cpu_control_unit;

  typedef struct packed {
    logic       adr_sel, s_sel, pc_sel, pc_ld, pc_inc, ir_ld, w_en;
    logic [2:0] w_adr, r_adr, s_adr;
    logic [3:0] alu_op;
    logic       mem_req, mem_we, halted;
    logic [3:0] st;
  } outv_t;

  typedef struct packed {
    logic        rst;
    logic        ack;
    logic [2:0]  cnz;
    logic [15:0] ds;
    outv_t       exp;
  } cyc_t;

  logic        clk = 1'b0;
  logic        reset_r = 1'b1;
  logic        ack_in = 1'b0;
  logic        c_in = 1'b0, n_in = 1'b0, z_in = 1'b0;
  logic [15:0] ds = 16'h0;

  // Minimal exec unit: IR, PC and a register file written only by loads
  logic [15:0] ir_q = 16'h0;
  logic [15:0] dp_pc = 16'h0;
  logic [15:0] dp_regs [8];

  // Reference model state
  cyc_t        q[$];
  outv_t       exp_q[$];
  outv_t       got_q[$];
  logic [15:0] pc_m = 16'h0;
  logic [15:0] regs_m [8];
  logic [2:0]  flags_m = 3'b000;

  int n_tests = 0;
  int n_fail  = 0;

  cpu_control_unit_if bus ();

  cpu_control_unit dut (
    .clk   (clk),
    .reset (reset_r),
    .bus   (bus)
  );

  assign bus.IR      = ir_q;
  assign bus.C       = c_in;
  assign bus.N       = n_in;
  assign bus.Z       = z_in;
  assign bus.mem_ack = ack_in;

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 8; i++) begin
      dp_regs[i] = 16'h0;
      regs_m[i]  = 16'h0;
    end
  end

  always @(posedge clk) begin
    if (bus.ir_ld) ir_q <= ds;
    if (bus.pc_inc) dp_pc <= dp_pc + 16'd1;
    else if (bus.pc_ld) dp_pc <= bus.pc_sel ? dp_regs[bus.R_Adr] : dp_pc + {{8{ir_q[7]}}, ir_q[7:0]};
    if (bus.W_en && bus.s_sel) dp_regs[bus.W_Adr] <= ds;
  end

  function automatic outv_t sample();
    outv_t o;
    o = '{bus.adr_sel, bus.s_sel, bus.pc_sel, bus.pc_ld, bus.pc_inc, bus.ir_ld, bus.W_en,
          bus.W_Adr, bus.R_Adr, bus.S_Adr, bus.ALU_OP, bus.mem_req, bus.mem_we, bus.halted, bus.state};
    return o;
  endfunction

  function automatic outv_t blank(input logic [3:0] st, input logic [15:0] ins);
    outv_t o;
    o = '0;
    o.st = st;
    if (st != 4'd0) begin
      o.w_adr = ins[11:9];
      o.r_adr = ins[8:6];
      o.s_adr = ins[5:3];
    end
    return o;
  endfunction

  function automatic void push(input logic rst, input logic ack, input logic [2:0] cnz,
                               input logic [15:0] d, input outv_t e);
    cyc_t c;
    c.rst = rst; c.ack = ack; c.cnz = cnz; c.ds = d; c.exp = e;
    q.push_back(c);
  endfunction

  function automatic logic [2:0] r3();
    return 3'($urandom);
  endfunction

  function automatic logic [15:0] r16();
    return 16'($urandom);
  endfunction

  function automatic void add_reset(input int n);
    for (int i = 0; i < n; i++) push(1'b1, 1'($urandom), r3(), r16(), blank(4'd0, 16'h0));
    flags_m = 3'b000;
  endfunction

  function automatic void add_fetch(input logic [15:0] ins, input int fw);
    outv_t o;
    for (int i = 0; i < fw; i++) begin
      o = blank(4'd0, ins); o.mem_req = 1'b1;
      push(1'b0, 1'b0, r3(), r16(), o);
    end
    o = blank(4'd0, ins); o.mem_req = 1'b1; o.ir_ld = 1'b1; o.pc_inc = 1'b1;
    push(1'b0, 1'b1, r3(), ins, o);
    pc_m = pc_m + 16'd1;
  endfunction

  // Expected cycle trace for one instruction after its fetch
  function automatic void add_exec(input logic [15:0] ins, input int mw, input logic [2:0] alu_cnz);
    outv_t       o;
    logic [3:0]  op;
    logic [15:0] d;
    logic        taken;
    op = ins[15:12];
    push(1'b0, 1'($urandom), r3(), r16(), blank(4'd1, ins));
    if (op <= 4'h9) begin
      o = blank(4'd2, ins); o.alu_op = op; o.w_en = 1'b1;
      push(1'b0, 1'($urandom), alu_cnz, r16(), o);
      flags_m = alu_cnz;
    end else if (op == 4'hA) begin
      for (int i = 0; i < mw; i++) begin
        o = blank(4'd3, ins); o.adr_sel = 1'b1; o.mem_req = 1'b1;
        push(1'b0, 1'b0, r3(), r16(), o);
      end
      d = r16();
      o = blank(4'd3, ins); o.adr_sel = 1'b1; o.mem_req = 1'b1; o.s_sel = 1'b1;
      o.alu_op = 4'h1; o.w_en = 1'b1;
      push(1'b0, 1'b1, r3(), d, o);
      regs_m[ins[11:9]] = d;
    end else if (op == 4'hB) begin
      for (int i = 0; i <= mw; i++) begin
        o = blank(4'd4, ins); o.adr_sel = 1'b1; o.alu_op = 4'h1; o.mem_req = 1'b1; o.mem_we = 1'b1;
        push(1'b0, (i == mw), r3(), r16(), o);
      end
    end else if (op == 4'hC || op == 4'hE) begin
      taken = (op == 4'hC) ? flags_m[0] : flags_m[1];
      o = blank(4'd5, ins); o.pc_ld = taken;
      push(1'b0, 1'($urandom), r3(), r16(), o);
      if (taken) pc_m = pc_m + {{8{ins[7]}}, ins[7:0]};
    end else if (op == 4'hD) begin
      o = blank(4'd6, ins); o.alu_op = 4'h2; o.pc_sel = 1'b1; o.pc_ld = 1'b1;
      push(1'b0, 1'($urandom), r3(), r16(), o);
      pc_m = regs_m[ins[8:6]];
    end else begin
      o = blank(4'd7, ins); o.halted = 1'b1;
      push(1'b0, 1'($urandom), r3(), r16(), o);
    end
  endfunction

  function automatic void add_instr(input logic [15:0] ins, input int fw, input int mw, input logic [2:0] alu_cnz);
    add_fetch(ins, fw);
    add_exec(ins, mw, alu_cnz);
  endfunction

  // Plays the queued trace, one cycle per entry; inputs change just after the rising edge
  task automatic drive();
    cyc_t c;
    got_q.delete();
    exp_q.delete();
    while (q.size() > 0) begin
      c = q.pop_front();
      reset_r = c.rst;
      ack_in  = c.ack;
      {c_in, n_in, z_in} = c.cnz;
      ds = c.ds;
      @(negedge clk);
      got_q.push_back(sample());
      exp_q.push_back(c.exp);
      @(posedge clk);
      #1;
    end
    reset_r = 1'b0;
    ack_in  = 1'b0;
  endtask

  task automatic test_reset();
    add_reset(3);
    drive();
    for (int i = 0; i < exp_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL reset cyc%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_fetch_alu();
    add_instr(16'h3298, 2, 0, 3'b101);
    drive();
    for (int i = 0; i < exp_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL fetch_alu cyc%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_load();
    outv_t o;
    add_fetch(16'hA280, 0);
    push(1'b0, 1'b0, r3(), r16(), blank(4'd1, 16'hA280));
    o = blank(4'd3, 16'hA280); o.adr_sel = 1'b1; o.mem_req = 1'b1; o.s_sel = 1'b1;
    o.alu_op = 4'h1; o.w_en = 1'b1;
    push(1'b0, 1'b1, r3(), 16'h1234, o);
    regs_m[1] = 16'h1234;
    drive();
    for (int i = 0; i < exp_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL load cyc%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    n_tests++;
    if (dp_regs[1] !== 16'h1234) begin
      n_fail++;
      $display("FAIL load_reg1 got=%h exp=%h", dp_regs[1], 16'h1234);
    end
  endtask

  task automatic test_branch();
    add_instr(16'h1000, 0, 0, 3'b001);
    add_instr(16'hC0FE, 1, 0, 3'b000);
    add_instr(16'h1000, 0, 0, 3'b000);
    add_instr(16'hC0FE, 0, 0, 3'b000);
    add_instr(16'h2000, 0, 0, 3'b010);
    add_instr(16'hE005, 0, 0, 3'b000);
    add_instr(16'hD080, 0, 0, 3'b000);
    drive();
    for (int i = 0; i < exp_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL branch cyc%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    n_tests++;
    if (dp_pc !== pc_m) begin
      n_fail++;
      $display("FAIL branch_pc got=%h exp=%h", dp_pc, pc_m);
    end
  endtask

  task automatic test_store_reset();
    outv_t o;
    add_instr(16'hB0D8, 0, 3, 3'b000);
    add_fetch(16'hB0D8, 1);
    push(1'b0, 1'b0, r3(), r16(), blank(4'd1, 16'hB0D8));
    for (int i = 0; i < 2; i++) begin
      o = blank(4'd4, 16'hB0D8); o.adr_sel = 1'b1; o.alu_op = 4'h1; o.mem_req = 1'b1; o.mem_we = 1'b1;
      push(1'b0, 1'b0, r3(), r16(), o);
    end
    add_reset(1);
    add_instr(16'h4AC8, 0, 0, 3'b111);
    drive();
    for (int i = 0; i < exp_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL store_reset cyc%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_halt();
    outv_t o;
    add_instr(16'hF000, 0, 0, 3'b000);
    for (int i = 0; i < 20; i++) begin
      o = blank(4'd7, 16'hF000); o.halted = 1'b1;
      push(1'b0, 1'($urandom), r3(), r16(), o);
    end
    add_reset(1);
    add_instr(16'h5123, 1, 0, 3'b000);
    drive();
    for (int i = 0; i < exp_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL halt cyc%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] ins;
    for (int k = 0; k < 40; k++) begin
      ins = r16();
      ins[15:12] = 4'($urandom_range(0, 14));
      add_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), r3());
    end
    drive();
    for (int i = 0; i < exp_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL random cyc%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    n_tests++;
    if (dp_pc !== pc_m) begin
      n_fail++;
      $display("FAIL random_pc got=%h exp=%h", dp_pc, pc_m);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_fetch_alu();
    test_load();
    test_branch();
    test_store_reset();
    test_halt();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
